// File: rtl/decode_scoreboard_pkg.sv
// Shared decode/scoreboard definitions: register index width, link register
// default, and the operand/destination bundle passed from decode to the
// hazard checker. Latency: n/a. Backpressure: n/a.
package decode_scoreboard_pkg;

  localparam int REG_IDX_W        = 5;
  localparam int LINK_REG_DEFAULT = 31;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // One register file's worth of hazard-relevant decode fields.
  typedef struct packed {
    logic     rd1_en;
    reg_idx_t rd1;
    logic     rd2_en;
    reg_idx_t rd2;
    logic     wr_en;
    reg_idx_t dst;
  } dec_hazard_t;

endpackage

// File: rtl/decode_scoreboard_pending_table.sv
// Pending-write bit table for one register file, with same-cycle clear bypass.
// Latency: hit flags combinational; set/clear land on the next rising edge.
// Backpressure: none; set beats clear when both hit the same entry.
// Ports: clk/rst_n; i_set_*, i_clr_* update ports; i_chk source/dest check
//        bundle; o_rd1_hit/o_rd2_hit/o_dst_hit, o_any_pending (effective),
//        o_busy (registered).
module pending_table
  import decode_scoreboard_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_set_en,
  input  reg_idx_t    i_set_idx,
  input  logic        i_clr_en,
  input  reg_idx_t    i_clr_idx,
  input  dec_hazard_t i_chk,
  output logic        o_rd1_hit,
  output logic        o_rd2_hit,
  output logic        o_dst_hit,
  output logic        o_any_pending,
  output logic        o_busy
);

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_set_mask;
  logic [DEPTH-1:0] w_clr_mask;
  logic [DEPTH-1:0] w_eff;

  assign w_set_mask = i_set_en ? (DEPTH'(1) << i_set_idx) : '0;
  assign w_clr_mask = i_clr_en ? (DEPTH'(1) << i_clr_idx) : '0;

  // Register file is write-through, so a writeback this cycle already
  // satisfies readers and writers looking at the same entry.
  assign w_eff = r_pend & ~w_clr_mask;

  assign o_rd1_hit     = i_chk.rd1_en & w_eff[i_chk.rd1];
  assign o_rd2_hit     = i_chk.rd2_en & w_eff[i_chk.rd2];
  assign o_dst_hit     = i_chk.wr_en  & w_eff[i_chk.dst];
  assign o_any_pending = |w_eff;
  assign o_busy        = |r_pend;

  // Set applied after clear so a same-cycle issue keeps the entry pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
    end
  end

endmodule

// File: rtl/decode_scoreboard.sv
// Register-hazard scoreboard holding decode until its operands and
// destinations are free; drains and latches on halt.
// Latency: dec_ready/issue_fire combinational; state updates next edge.
// Backpressure: dec_ready low on hazard, !ex_ready, halt with pending
//               writes, or once halted (until reset).
// Ports: dec_valid/dec_ready/ex_ready/issue_fire handshake; scalar and vector
//        source/destination fields; s_/v_ writeback; busy, halted, stall_cycles.
module decode_scoreboard
  import decode_scoreboard_pkg::*;
#(
  parameter int NUM_SREG = 32,
  parameter int NUM_VREG = 32,
  parameter int LINK_REG = LINK_REG_DEFAULT,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic             ex_ready,
  output logic             issue_fire,
  input  logic             r_read1,
  input  logic             r_read2,
  input  reg_idx_t         s_src1,
  input  reg_idx_t         s_src2,
  input  logic             v_read1,
  input  logic             v_read2,
  input  reg_idx_t         v_src1,
  input  reg_idx_t         v_src2,
  input  logic             register_wr_en,
  input  reg_idx_t         s_dst,
  input  logic             store_pc,
  input  logic             vector_wr_en,
  input  reg_idx_t         v_dst,
  input  logic             halt,
  input  logic             s_wb_valid,
  input  reg_idx_t         s_wb_reg,
  input  logic             v_wb_valid,
  input  reg_idx_t         v_wb_reg,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  dec_hazard_t      w_s_chk;
  dec_hazard_t      w_v_chk;
  reg_idx_t         w_s_dst;
  logic             w_s_rd1_hit, w_s_rd2_hit, w_s_dst_hit, w_s_any, w_s_busy;
  logic             w_v_rd1_hit, w_v_rd2_hit, w_v_dst_hit, w_v_any, w_v_busy;
  logic             w_hazard;
  logic             w_busy_eff;
  logic             r_halted;
  logic [CNT_W-1:0] r_stall;

  // jal/jalr write the link register regardless of the decoded rd field.
  assign w_s_dst = store_pc ? REG_IDX_W'(LINK_REG) : s_dst;

  always_comb begin
    w_s_chk        = '0;
    w_s_chk.rd1_en = r_read1;
    w_s_chk.rd1    = s_src1;
    w_s_chk.rd2_en = r_read2;
    w_s_chk.rd2    = s_src2;
    w_s_chk.wr_en  = register_wr_en;
    w_s_chk.dst    = w_s_dst;
    w_v_chk        = '0;
    w_v_chk.rd1_en = v_read1;
    w_v_chk.rd1    = v_src1;
    w_v_chk.rd2_en = v_read2;
    w_v_chk.rd2    = v_src2;
    w_v_chk.wr_en  = vector_wr_en;
    w_v_chk.dst    = v_dst;
  end

  pending_table #(.DEPTH(NUM_SREG)) u_s_pend (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_set_en      (issue_fire & register_wr_en),
    .i_set_idx     (w_s_dst),
    .i_clr_en      (s_wb_valid),
    .i_clr_idx     (s_wb_reg),
    .i_chk         (w_s_chk),
    .o_rd1_hit     (w_s_rd1_hit),
    .o_rd2_hit     (w_s_rd2_hit),
    .o_dst_hit     (w_s_dst_hit),
    .o_any_pending (w_s_any),
    .o_busy        (w_s_busy)
  );

  pending_table #(.DEPTH(NUM_VREG)) u_v_pend (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_set_en      (issue_fire & vector_wr_en),
    .i_set_idx     (v_dst),
    .i_clr_en      (v_wb_valid),
    .i_clr_idx     (v_wb_reg),
    .i_chk         (w_v_chk),
    .o_rd1_hit     (w_v_rd1_hit),
    .o_rd2_hit     (w_v_rd2_hit),
    .o_dst_hit     (w_v_dst_hit),
    .o_any_pending (w_v_any),
    .o_busy        (w_v_busy)
  );

  assign w_hazard   = w_s_rd1_hit | w_s_rd2_hit | w_s_dst_hit |
                      w_v_rd1_hit | w_v_rd2_hit | w_v_dst_hit;
  assign w_busy_eff = w_s_any | w_v_any;

  // Halt may only issue once every outstanding write has retired.
  assign dec_ready    = ~r_halted & ex_ready & ~w_hazard & ~(halt & w_busy_eff);
  assign issue_fire   = dec_valid & dec_ready;
  assign busy         = w_s_busy | w_v_busy;
  assign halted       = r_halted;
  assign stall_cycles = r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
      r_stall  <= '0;
    end else begin
      if (issue_fire && halt) begin
        r_halted <= 1'b1;
      end
      if (dec_valid && !dec_ready && (r_stall != {CNT_W{1'b1}})) begin
        r_stall <= r_stall + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Self-checking bench for decode_scoreboard: directed scenarios then random
// traffic, each cycle's expected outputs queued by a reference model.
// Latency: n/a. Backpressure: n/a.
module tb_decode_scoreboard;

  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic          dec_valid, dec_ready, ex_ready, issue_fire;
  logic          r_read1, r_read2, v_read1, v_read2;
  logic [4:0]    s_src1, s_src2, v_src1, v_src2;
  logic          register_wr_en, store_pc, vector_wr_en, halt;
  logic [4:0]    s_dst, v_dst;
  logic          s_wb_valid, v_wb_valid;
  logic [4:0]    s_wb_reg, v_wb_reg;
  logic          busy, halted;
  logic [CW-1:0] stall_cycles;

  decode_scoreboard #(.NUM_SREG(32), .NUM_VREG(32), .LINK_REG(31), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .ex_ready(ex_ready),
    .issue_fire(issue_fire),
    .r_read1(r_read1), .r_read2(r_read2), .s_src1(s_src1), .s_src2(s_src2),
    .v_read1(v_read1), .v_read2(v_read2), .v_src1(v_src1), .v_src2(v_src2),
    .register_wr_en(register_wr_en), .s_dst(s_dst), .store_pc(store_pc),
    .vector_wr_en(vector_wr_en), .v_dst(v_dst), .halt(halt),
    .s_wb_valid(s_wb_valid), .s_wb_reg(s_wb_reg),
    .v_wb_valid(v_wb_valid), .v_wb_reg(v_wb_reg),
    .busy(busy), .halted(halted), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       rst_n, dec_valid, ex_ready;
    bit       r_read1, r_read2, v_read1, v_read2;
    bit [4:0] s_src1, s_src2, v_src1, v_src2;
    bit       register_wr_en, store_pc, vector_wr_en, halt;
    bit [4:0] s_dst, v_dst;
    bit       s_wb_valid, v_wb_valid;
    bit [4:0] s_wb_reg, v_wb_reg;
  } stim_t;

  typedef struct packed {
    logic          ready;
    logic          fire;
    logic          busy;
    logic          halted;
    logic [CW-1:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: sets of registers awaiting a write, plus counters.
  bit m_s[32];
  bit m_v[32];
  bit m_halted;
  int m_stall;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.rst_n    = 1;
    s.ex_ready = 1;
    return s;
  endfunction

  function automatic void model_reset();
    foreach (m_s[i]) m_s[i] = 0;
    foreach (m_v[i]) m_v[i] = 0;
    m_halted = 0;
    m_stall  = 0;
  endfunction

  // Expected outputs for this cycle, then the state after the coming edge.
  function automatic exp_t model_step(input stim_t s);
    exp_t e;
    bit s_eff[32];
    bit v_eff[32];
    bit any_eff, any_reg, hazard, ready;
    int sd;
    if (!s.rst_n) model_reset();
    any_eff = 0;
    any_reg = 0;
    for (int i = 0; i < 32; i++) begin
      s_eff[i] = m_s[i] && !(s.s_wb_valid && s.s_wb_reg == i);
      v_eff[i] = m_v[i] && !(s.v_wb_valid && s.v_wb_reg == i);
      any_eff |= s_eff[i] | v_eff[i];
      any_reg |= m_s[i] | m_v[i];
    end
    sd = s.store_pc ? 31 : int'(s.s_dst);
    hazard = (s.r_read1 && s_eff[s.s_src1]) || (s.r_read2 && s_eff[s.s_src2]) ||
             (s.v_read1 && v_eff[s.v_src1]) || (s.v_read2 && v_eff[s.v_src2]) ||
             (s.register_wr_en && s_eff[sd]) || (s.vector_wr_en && v_eff[s.v_dst]);
    ready   = !m_halted && s.ex_ready && !hazard && !(s.halt && any_eff);
    e.ready  = ready;
    e.fire   = s.dec_valid && ready;
    e.busy   = any_reg;
    e.halted = m_halted;
    e.stall  = CW'(m_stall);
    if (s.rst_n) begin
      if (s.s_wb_valid) m_s[s.s_wb_reg] = 0;
      if (s.v_wb_valid) m_v[s.v_wb_reg] = 0;
      if (e.fire && s.register_wr_en) m_s[sd] = 1;
      if (e.fire && s.vector_wr_en) m_v[s.v_dst] = 1;
      if (e.fire && s.halt) m_halted = 1;
      if (s.dec_valid && !ready && m_stall < (1 << CW) - 1) m_stall++;
    end
    return e;
  endfunction

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    rst_n = s.rst_n; dec_valid = s.dec_valid; ex_ready = s.ex_ready;
    r_read1 = s.r_read1; r_read2 = s.r_read2; s_src1 = s.s_src1; s_src2 = s.s_src2;
    v_read1 = s.v_read1; v_read2 = s.v_read2; v_src1 = s.v_src1; v_src2 = s.v_src2;
    register_wr_en = s.register_wr_en; s_dst = s.s_dst; store_pc = s.store_pc;
    vector_wr_en = s.vector_wr_en; v_dst = s.v_dst; halt = s.halt;
    s_wb_valid = s.s_wb_valid; s_wb_reg = s.s_wb_reg;
    v_wb_valid = s.v_wb_valid; v_wb_reg = s.v_wb_reg;
    exp_q.push_back(model_step(s));
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dec_ready",    int'(dec_ready),    int'(e.ready));
        chk("issue_fire",   int'(issue_fire),   int'(e.fire));
        chk("busy",         int'(busy),         int'(e.busy));
        chk("halted",       int'(halted),       int'(e.halted));
        chk("stall_cycles", int'(stall_cycles), int'(e.stall));
      end
    end
  end

  function automatic bit [4:0] pick_pending(input bit vec);
    int start;
    start = $urandom_range(31, 0);
    for (int k = 0; k < 32; k++) begin
      if (vec ? m_v[(start + k) % 32] : m_s[(start + k) % 32]) return 5'((start + k) % 32);
    end
    return 5'(start);
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = idle();
    s.dec_valid      = ($urandom_range(9, 0) < 8);
    s.ex_ready       = ($urandom_range(9, 0) < 8);
    s.r_read1        = $urandom_range(1, 0);
    s.r_read2        = $urandom_range(1, 0);
    s.v_read1        = ($urandom_range(3, 0) == 0);
    s.v_read2        = ($urandom_range(3, 0) == 0);
    s.s_src1         = 5'($urandom_range(31, 0));
    s.s_src2         = 5'($urandom_range(31, 0));
    s.v_src1         = 5'($urandom_range(31, 0));
    s.v_src2         = 5'($urandom_range(31, 0));
    s.register_wr_en = $urandom_range(1, 0);
    s.store_pc       = s.register_wr_en && ($urandom_range(7, 0) == 0);
    s.s_dst          = 5'($urandom_range(31, 0));
    s.vector_wr_en   = ($urandom_range(2, 0) == 0);
    s.v_dst          = 5'($urandom_range(31, 0));
    s.halt           = ($urandom_range(127, 0) == 0);
    s.s_wb_valid     = $urandom_range(1, 0);
    s.s_wb_reg       = $urandom_range(1, 0) ? pick_pending(0) : 5'($urandom_range(31, 0));
    s.v_wb_valid     = $urandom_range(1, 0);
    s.v_wb_reg       = $urandom_range(1, 0) ? pick_pending(1) : 5'($urandom_range(31, 0));
    return s;
  endfunction

  initial begin
    stim_t s;
    rst_n = 1'b0;
    model_reset();

    // Reset, then an independent reader issues immediately.
    s = idle(); s.rst_n = 0;
    step(s); step(s);
    s = idle(); s.dec_valid = 1; s.r_read1 = 1; s.s_src1 = 3;
    step(s);

    // RAW on r5: four stall cycles, writeback unblocks in the same cycle.
    s = idle(); s.dec_valid = 1; s.register_wr_en = 1; s.s_dst = 5;
    step(s);
    s = idle(); s.dec_valid = 1; s.r_read1 = 1; s.s_src1 = 5;
    repeat (4) step(s);
    s.s_wb_valid = 1; s.s_wb_reg = 5;
    step(s);

    // jal writes the link register; jalr reading r31 waits for it.
    s = idle(); s.dec_valid = 1; s.register_wr_en = 1; s.store_pc = 1; s.s_dst = 0;
    step(s);
    s = idle(); s.dec_valid = 1; s.r_read1 = 1; s.s_src1 = 31;
    repeat (3) step(s);
    s.s_wb_valid = 1; s.s_wb_reg = 31;
    step(s);

    // vldr: vector writeback alone does not release the scalar reader.
    s = idle(); s.dec_valid = 1; s.register_wr_en = 1; s.s_dst = 2;
    s.vector_wr_en = 1; s.v_dst = 7;
    step(s);
    s = idle(); s.dec_valid = 1; s.r_read1 = 1; s.s_src1 = 2;
    s.v_wb_valid = 1; s.v_wb_reg = 7;
    step(s);
    s.v_wb_valid = 0;
    step(s);
    s.s_wb_valid = 1; s.s_wb_reg = 2;
    step(s);

    // WAW on r9; reissue with same-cycle writeback keeps r9 pending.
    s = idle(); s.dec_valid = 1; s.register_wr_en = 1; s.s_dst = 9;
    step(s); step(s); step(s);
    s.s_wb_valid = 1; s.s_wb_reg = 9;
    step(s);
    s = idle(); s.dec_valid = 1; s.r_read2 = 1; s.s_src2 = 9;
    step(s); step(s);
    s.s_wb_valid = 1; s.s_wb_reg = 9;
    step(s);

    // Halt drains two outstanding writes, then blocks until reset.
    s = idle(); s.dec_valid = 1; s.register_wr_en = 1; s.s_dst = 10;
    s.vector_wr_en = 1; s.v_dst = 11;
    step(s);
    s = idle(); s.dec_valid = 1; s.halt = 1;
    repeat (3) step(s);
    s.s_wb_valid = 1; s.s_wb_reg = 10;
    step(s);
    s.s_wb_valid = 0; s.v_wb_valid = 1; s.v_wb_reg = 11;
    step(s);
    s = idle(); s.dec_valid = 1;
    repeat (270) step(s);
    s = idle(); s.rst_n = 0;
    step(s);
    s = idle(); s.dec_valid = 1;
    step(s); step(s);

    // Random traffic in epochs, each closed by a reset pulse.
    for (int ep = 0; ep < 8; ep++) begin
      for (int c = 0; c < 200; c++) step(rand_stim());
      s = idle(); s.rst_n = 0; s.dec_valid = 1;
      step(s);
    end
    step(idle());

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
